csi_frame_controller: RTL and testbench

Capture sequencer that sits behind the CSI-2 packet receiver (`camera`) and decides which image data leaves the receiver.
- Arms on software request, or re-arms continuously.
- Locks onto Frame Start on one selected virtual channel.
- Tracks line and word position across long packets, forwards payload words through a valid/ready output register, and flags protocol, length and overflow faults.
- Runs in the single receiver-side clock domain; the upstream cannot stall, so the controller never back-pressures it.

---
 rtl/csi_pkg.sv | 23 ++
 rtl/csi_output_register.sv | 46 ++++
 rtl/csi_frame_controller.sv | 165 ++++++++++++++++
 tb/tb_csi_frame_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csi_pkg.sv
// Shared CSI-2 capture definitions: data type codes, capture states and
// the long-packet classifier.
package csi_pkg;

  localparam logic [7:0] DT_FRAME_START = 8'h00;
  localparam logic [7:0] DT_FRAME_END   = 8'h01;
  localparam logic [7:0] DT_LINE_START  = 8'h02;
  localparam logic [7:0] DT_LINE_END    = 8'h03;
  localparam logic [7:0] DT_LONG_MIN    = 8'h18;
  localparam logic [7:0] DT_LONG_MAX    = 8'h2F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FRAME = 2'd2,
    LINE  = 2'd3
  } state_t;

  function automatic logic is_long_packet(input logic [7:0] data_type);
    return (data_type >= DT_LONG_MIN) && (data_type <= DT_LONG_MAX);
  endfunction

endpackage

// File: rtl/csi_output_register.sv
// 32-bit valid/ready holding register. A word loads when the register is
// empty or the downstream accepts; a word arriving while stalled is dropped.
module csi_output_register (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        drop
);

  // Handshake: a word transfers in any cycle where out_valid && out_ready.
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        load;

  assign load = in_valid && (!valid_q || out_ready);
  assign drop = in_valid && valid_q && !out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/csi_frame_controller.sv
// Capture sequencer behind the CSI-2 packet receiver: arms, locks onto a
// virtual channel's frame, tracks line/word position and forwards payload.
module csi_frame_controller
  import csi_pkg::*;
#(
  parameter int LINE_WIDTH       = 12,
  parameter int WORD_INDEX_WIDTH = 14
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        capture_request,
  input  logic                        continuous,
  input  logic [1:0]                  vc_select,
  input  logic                        header_valid,
  input  logic [1:0]                  virtual_channel,
  input  logic [7:0]                  data_type,
  input  logic [15:0]                 word_count,
  input  logic                        payload_valid,
  input  logic [31:0]                 payload,
  output logic                        pixel_valid,
  output logic [31:0]                 pixel_data,
  input  logic                        pixel_ready,
  output logic [LINE_WIDTH-1:0]       line_index,
  output logic [WORD_INDEX_WIDTH-1:0] word_index,
  output logic                        frame_start,
  output logic                        line_start,
  output logic                        frame_end,
  output logic [15:0]                 frame_count,
  output logic                        busy,
  output logic                        error_protocol,
  output logic                        error_length,
  output logic                        error_overflow,
  output logic [1:0]                  debug_state
);

  state_t                      state_q, state_d, eff_state;
  logic [LINE_WIDTH-1:0]       line_q, line_d, line_inc;
  logic [WORD_INDEX_WIDTH-1:0] word_q, word_d;
  logic [16:0]                 expected_q, expected_d;
  logic [15:0]                 fcount_q, fcount_d;
  logic                        fs_q, fs_d, ls_q, ls_d, fe_q, fe_d;
  logic                        err_p_q, err_p_d, err_l_q, err_l_d, err_o_q, err_o_d;
  logic                        hdr_ok, handle_frame, offer, ovf_drop;

  assign hdr_ok   = header_valid && (virtual_channel == vc_select);
  assign line_inc = (line_q == '1) ? line_q : line_q + LINE_WIDTH'(1);

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    word_d       = word_q;
    expected_d   = expected_q;
    fcount_d     = fcount_q;
    fs_d         = 1'b0;
    ls_d         = 1'b0;
    fe_d         = 1'b0;
    err_p_d      = err_p_q;
    err_l_d      = err_l_q;
    err_o_d      = err_o_q | ovf_drop;
    offer        = 1'b0;
    handle_frame = 1'b0;
    eff_state    = state_q;

    // The payload word is consumed before any header arriving in the same cycle.
    if (state_q == LINE && payload_valid) begin
      offer  = 1'b1;
      word_d = word_q + WORD_INDEX_WIDTH'(1);
      if (17'(word_q) == expected_q - 17'd1) begin
        eff_state = FRAME;
        line_d    = line_inc;
      end
    end
    state_d = eff_state;

    case (eff_state)
      IDLE:  if (capture_request || continuous) state_d = ARMED;
      ARMED: if (hdr_ok && data_type == DT_FRAME_START) begin
        state_d = FRAME;
        fs_d    = 1'b1;
        line_d  = '0;
      end
      FRAME: handle_frame = hdr_ok;
      LINE:  if (hdr_ok) begin
        err_l_d      = 1'b1;
        line_d       = line_inc;
        handle_frame = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (handle_frame) begin
      state_d = FRAME;
      if (is_long_packet(data_type)) begin
        if (word_count != 16'd0) begin
          state_d    = LINE;
          ls_d       = 1'b1;
          word_d     = '0;
          expected_d = ({1'b0, word_count} + 17'd3) >> 2;
        end else begin
          err_l_d = 1'b1;
        end
      end else if (data_type == DT_FRAME_END) begin
        fe_d     = 1'b1;
        fcount_d = fcount_q + 16'd1;
        state_d  = continuous ? ARMED : IDLE;
      end else if (data_type == DT_FRAME_START) begin
        err_p_d = 1'b1;
        fs_d    = 1'b1;
        line_d  = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      line_q     <= '0;
      word_q     <= '0;
      expected_q <= 17'd0;
      fcount_q   <= 16'd0;
      fs_q       <= 1'b0;
      ls_q       <= 1'b0;
      fe_q       <= 1'b0;
      err_p_q    <= 1'b0;
      err_l_q    <= 1'b0;
      err_o_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      word_q     <= word_d;
      expected_q <= expected_d;
      fcount_q   <= fcount_d;
      fs_q       <= fs_d;
      ls_q       <= ls_d;
      fe_q       <= fe_d;
      err_p_q    <= err_p_d;
      err_l_q    <= err_l_d;
      err_o_q    <= err_o_d;
    end
  end

  csi_output_register u_out (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (offer),
    .in_data   (payload),
    .out_ready (pixel_ready),
    .out_valid (pixel_valid),
    .out_data  (pixel_data),
    .drop      (ovf_drop)
  );

  assign line_index     = line_q;
  assign word_index     = word_q;
  assign frame_start    = fs_q;
  assign line_start     = ls_q;
  assign frame_end      = fe_q;
  assign frame_count    = fcount_q;
  assign busy           = (state_q != IDLE);
  assign error_protocol = err_p_q;
  assign error_length   = err_l_q;
  assign error_overflow = err_o_q;
  assign debug_state    = state_q;

endmodule

// File: tb/tb_csi_frame_controller.sv
// Self-checking bench for csi_frame_controller: scoreboarded pixel stream
// plus directed checks of pulses, indices, counters and sticky errors.
module tb_csi_frame_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        capture_request, continuous;
  logic [1:0]  vc_select;
  logic        header_valid;
  logic [1:0]  virtual_channel;
  logic [7:0]  data_type;
  logic [15:0] word_count;
  logic        payload_valid;
  logic [31:0] payload;
  logic        pixel_valid;
  logic [31:0] pixel_data;
  logic        pixel_ready;
  logic [11:0] line_index;
  logic [13:0] word_index;
  logic        frame_start, line_start, frame_end;
  logic [15:0] frame_count;
  logic        busy, error_protocol, error_length, error_overflow;
  logic [1:0]  debug_state;

  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_FRAME = 2'd2, S_LINE = 2'd3;

  int checks = 0;
  int failures = 0;
  int fs_cnt = 0, ls_cnt = 0, fe_cnt = 0, pop_cnt = 0;
  logic [31:0] exp_q[$];

  csi_frame_controller dut (
    .clock(clock), .reset(reset), .capture_request(capture_request),
    .continuous(continuous), .vc_select(vc_select), .header_valid(header_valid),
    .virtual_channel(virtual_channel), .data_type(data_type), .word_count(word_count),
    .payload_valid(payload_valid), .payload(payload), .pixel_valid(pixel_valid),
    .pixel_data(pixel_data), .pixel_ready(pixel_ready), .line_index(line_index),
    .word_index(word_index), .frame_start(frame_start), .line_start(line_start),
    .frame_end(frame_end), .frame_count(frame_count), .busy(busy),
    .error_protocol(error_protocol), .error_length(error_length),
    .error_overflow(error_overflow), .debug_state(debug_state)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard and pulse monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_start) fs_cnt++;
      if (line_start)  ls_cnt++;
      if (frame_end)   fe_cnt++;
      if (pixel_valid && pixel_ready) begin
        pop_cnt++;
        check_eq("pix_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("pix_data", pixel_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_counts();
    fs_cnt = 0; ls_cnt = 0; fe_cnt = 0; pop_cnt = 0;
  endtask

  task automatic request();
    capture_request = 1'b1;
    tick();
    capture_request = 1'b0;
  endtask

  task automatic hdr(input logic [1:0] vc, input logic [7:0] dt, input logic [15:0] wc);
    header_valid = 1'b1; virtual_channel = vc; data_type = dt; word_count = wc;
    tick();
    header_valid = 1'b0;
  endtask

  task automatic word(input logic [31:0] d, input bit expect_out);
    payload_valid = 1'b1; payload = d;
    if (expect_out) exp_q.push_back(d);
    tick();
    payload_valid = 1'b0;
  endtask

  task automatic send_line(input logic [1:0] vc, input logic [15:0] wc, input bit expect_out);
    hdr(vc, 8'h2A, wc);
    for (int i = 0; i < ((int'(wc) + 3) >> 2); i++) word($urandom, expect_out);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pvalid"}, 32'(pixel_valid), 32'd0);
    check_eq({tag, "_pdata"}, pixel_data, 32'd0);
    check_eq({tag, "_line"}, 32'(line_index), 32'd0);
    check_eq({tag, "_word"}, 32'(word_index), 32'd0);
    check_eq({tag, "_pulses"}, {29'd0, frame_start, line_start, frame_end}, 32'd0);
    check_eq({tag, "_fcount"}, 32'(frame_count), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_errs"}, {29'd0, error_protocol, error_length, error_overflow}, 32'd0);
    check_eq({tag, "_state"}, 32'(debug_state), 32'(S_IDLE));
  endtask

  initial begin
    reset = 1'b1; capture_request = 1'b0; continuous = 1'b0; vc_select = 2'd0;
    header_valid = 1'b0; virtual_channel = 2'd0; data_type = 8'h00; word_count = 16'd0;
    payload_valid = 1'b0; payload = 32'd0; pixel_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // Single capture on vc 0
    clear_counts();
    request();
    check_eq("t1_armed", 32'(debug_state), 32'(S_ARMED));
    hdr(2'd0, 8'h00, 16'd0);
    send_line(2'd0, 16'd8, 1'b1);
    send_line(2'd0, 16'd8, 1'b1);
    hdr(2'd0, 8'h01, 16'd0);
    tick();
    check_eq("t1_fs", fs_cnt, 1);
    check_eq("t1_ls", ls_cnt, 2);
    check_eq("t1_fe", fe_cnt, 1);
    check_eq("t1_pops", pop_cnt, 4);
    check_eq("t1_line", 32'(line_index), 32'd2);
    check_eq("t1_fcount", 32'(frame_count), 32'd1);
    check_eq("t1_busy", 32'(busy), 32'd0);
    check_eq("t1_state", 32'(debug_state), 32'(S_IDLE));

    // Virtual channel filter
    clear_counts();
    vc_select = 2'd1;
    request();
    hdr(2'd0, 8'h00, 16'd0);
    send_line(2'd0, 16'd8, 1'b0);
    hdr(2'd0, 8'h01, 16'd0);
    tick();
    check_eq("t2_vc0_fs", fs_cnt, 0);
    check_eq("t2_vc0_pops", pop_cnt, 0);
    check_eq("t2_vc0_state", 32'(debug_state), 32'(S_ARMED));
    hdr(2'd1, 8'h00, 16'd0);
    send_line(2'd1, 16'd8, 1'b1);
    hdr(2'd1, 8'h01, 16'd0);
    tick();
    check_eq("t2_vc1_pops", pop_cnt, 2);
    check_eq("t2_vc1_fcount", 32'(frame_count), 32'd2);
    check_eq("t2_vc1_state", 32'(debug_state), 32'(S_IDLE));
    vc_select = 2'd0;

    // Length rounding and truncation
    clear_counts();
    request();
    hdr(2'd0, 8'h00, 16'd0);
    send_line(2'd0, 16'd5, 1'b1);
    check_eq("t3_round_state", 32'(debug_state), 32'(S_FRAME));
    check_eq("t3_round_word", 32'(word_index), 32'd2);
    check_eq("t3_round_line", 32'(line_index), 32'd1);
    check_eq("t3_no_len_err", 32'(error_length), 32'd0);
    hdr(2'd0, 8'h2B, 16'd12);
    word($urandom, 1'b1);
    hdr(2'd0, 8'h2B, 16'd8);
    check_eq("t3_trunc_err", 32'(error_length), 32'd1);
    check_eq("t3_trunc_state", 32'(debug_state), 32'(S_LINE));
    check_eq("t3_trunc_word", 32'(word_index), 32'd0);
    check_eq("t3_trunc_line", 32'(line_index), 32'd2);
    check_eq("t3_trunc_ls", 32'(line_start), 32'd1);
    word($urandom, 1'b1);
    word($urandom, 1'b1);
    hdr(2'd0, 8'h01, 16'd0);
    tick();
    check_eq("t3_line", 32'(line_index), 32'd3);
    check_eq("t3_fcount", 32'(frame_count), 32'd3);

    // Overflow with the downstream stalled
    request();
    hdr(2'd0, 8'h00, 16'd0);
    hdr(2'd0, 8'h2A, 16'd8);
    pixel_ready = 1'b0;
    word(32'hA5A5_0001, 1'b1);
    check_eq("t4_no_ovf_yet", 32'(error_overflow), 32'd0);
    word(32'h5A5A_0002, 1'b0);
    check_eq("t4_held_valid", 32'(pixel_valid), 32'd1);
    check_eq("t4_held_data", pixel_data, 32'hA5A5_0001);
    check_eq("t4_ovf", 32'(error_overflow), 32'd1);
    check_eq("t4_word", 32'(word_index), 32'd2);
    pixel_ready = 1'b1;
    tick();
    check_eq("t4_drained", 32'(pixel_valid), 32'd0);
    hdr(2'd0, 8'h01, 16'd0);
    tick();

    // Continuous mode, deasserted during the third frame
    continuous = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      hdr(2'd0, 8'h00, 16'd0);
      if (f == 2) continuous = 1'b0;
      send_line(2'd0, 16'd4, 1'b1);
      hdr(2'd0, 8'h01, 16'd0);
      if (f == 1) check_eq("t5_rearmed", 32'(debug_state), 32'(S_ARMED));
    end
    tick();
    check_eq("t5_fcount", 32'(frame_count), 32'd7);
    check_eq("t5_state", 32'(debug_state), 32'(S_IDLE));

    // Protocol error on a second Frame Start
    clear_counts();
    request();
    hdr(2'd0, 8'h00, 16'd0);
    send_line(2'd0, 16'd4, 1'b1);
    check_eq("t6_line1", 32'(line_index), 32'd1);
    check_eq("t6_no_proto", 32'(error_protocol), 32'd0);
    hdr(2'd0, 8'h00, 16'd0);
    check_eq("t6_proto", 32'(error_protocol), 32'd1);
    check_eq("t6_line0", 32'(line_index), 32'd0);
    check_eq("t6_fs_pulse", 32'(frame_start), 32'd1);
    check_eq("t6_state", 32'(debug_state), 32'(S_FRAME));

    // Reset in LINE with a held word
    hdr(2'd0, 8'h2A, 16'd8);
    pixel_ready = 1'b0;
    word($urandom, 1'b0);
    check_eq("t7_pre_state", 32'(debug_state), 32'(S_LINE));
    reset = 1'b1;
    tick();
    check_reset_outputs("t7");
    reset = 1'b0;
    pixel_ready = 1'b1;
    repeat (2) tick();

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
